// File: rtl/divisor_sequencial.sv
// Sequential restoring divider: splits an unsigned WIDTH_N-bit dividend by a WIDTH_D-bit divisor,
// producing one quotient bit per clock with a start/busy/done handshake.
module divisor_sequencial #(
    parameter int WIDTH_N = 16,
    parameter int WIDTH_D = 8
) (
    input  logic               p_Clock,
    input  logic               p_Clear,
    input  logic               p_Start,
    input  logic [WIDTH_N-1:0] p_Dividend,
    input  logic [WIDTH_D-1:0] p_Divisor,
    output logic               p_Busy,
    output logic               p_Done,
    output logic               p_DivZero,
    output logic [WIDTH_N-1:0] p_Quotient,
    output logic [WIDTH_D-1:0] p_Remainder
);

    localparam int CNT_W = $clog2(WIDTH_N + 1);

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    state_t             state, state_next;
    logic [WIDTH_N-1:0] shift_reg, shift_next;
    logic [WIDTH_D-1:0] divisor_reg, divisor_next;
    logic [WIDTH_D:0]   partial, partial_next;
    logic [CNT_W-1:0]   count, count_next;
    logic               done_next;
    logic               divzero_next;
    logic [WIDTH_N-1:0] quotient_next;
    logic [WIDTH_D-1:0] remainder_next;

    logic [WIDTH_D:0]   trial;
    logic [WIDTH_D+1:0] sub_sum;
    logic [WIDTH_D:0]   difference;
    logic               fits;

    // Adder in subtract mode (a + ~b + 1); the carry out means no borrow, i.e. trial >= divisor.
    always_comb begin
        trial      = {partial[WIDTH_D-1:0], shift_reg[WIDTH_N-1]};
        sub_sum    = {1'b0, trial} + {1'b0, ~{1'b0, divisor_reg}} + (WIDTH_D+2)'(1);
        fits       = sub_sum[WIDTH_D+1];
        difference = sub_sum[WIDTH_D:0];
    end

    always_comb begin
        state_next     = state;
        shift_next     = shift_reg;
        divisor_next   = divisor_reg;
        partial_next   = partial;
        count_next     = count;
        done_next      = 1'b0;
        divzero_next   = p_DivZero;
        quotient_next  = p_Quotient;
        remainder_next = p_Remainder;

        case (state)
            IDLE: begin
                if (p_Start) begin
                    if (p_Divisor != '0) begin
                        shift_next   = p_Dividend;
                        divisor_next = p_Divisor;
                        partial_next = '0;
                        count_next   = CNT_W'(WIDTH_N);
                        state_next   = CALC;
                    end else begin
                        // Divide-by-zero resolves in a single edge without entering CALC.
                        quotient_next  = '1;
                        remainder_next = p_Dividend[WIDTH_D-1:0];
                        divzero_next   = 1'b1;
                        done_next      = 1'b1;
                    end
                end
            end

            CALC: begin
                partial_next = fits ? difference : trial;
                shift_next   = {shift_reg[WIDTH_N-2:0], fits};
                count_next   = count - CNT_W'(1);
                if (count == CNT_W'(1)) begin
                    quotient_next  = shift_next;
                    remainder_next = partial_next[WIDTH_D-1:0];
                    divzero_next   = 1'b0;
                    done_next      = 1'b1;
                    state_next     = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge p_Clock or negedge p_Clear) begin
        if (!p_Clear) begin
            state       <= IDLE;
            shift_reg   <= '0;
            divisor_reg <= '0;
            partial     <= '0;
            count       <= '0;
            p_Done      <= 1'b0;
            p_DivZero   <= 1'b0;
            p_Quotient  <= '0;
            p_Remainder <= '0;
        end else begin
            state       <= state_next;
            shift_reg   <= shift_next;
            divisor_reg <= divisor_next;
            partial     <= partial_next;
            count       <= count_next;
            p_Done      <= done_next;
            p_DivZero   <= divzero_next;
            p_Quotient  <= quotient_next;
            p_Remainder <= remainder_next;
        end
    end

    assign p_Busy = (state == CALC);

endmodule

// File: tb/tb_divisor_sequencial.sv
// Scoreboard bench for divisor_sequencial: directed divisions push expected results,
// a negedge monitor pops and compares them whenever p_Done pulses.
module tb_divisor_sequencial;

    logic        p_Clock;
    logic        p_Clear;
    logic        p_Start;
    logic [15:0] p_Dividend;
    logic [7:0]  p_Divisor;
    logic        p_Busy;
    logic        p_Done;
    logic        p_DivZero;
    logic [15:0] p_Quotient;
    logic [7:0]  p_Remainder;

    typedef struct {
        logic [15:0] dividend;
        logic [7:0]  divisor;
        logic [15:0] quotient;
        logic [7:0]  remainder;
        logic        divzero;
        int          done_cycle;
    } expect_t;

    expect_t sb[$];
    int      cyc = 0;
    int      busy_run = 0;
    int      checks = 0;
    int      failures = 0;

    divisor_sequencial #(.WIDTH_N(16), .WIDTH_D(8)) dut (
        .p_Clock    (p_Clock),
        .p_Clear    (p_Clear),
        .p_Start    (p_Start),
        .p_Dividend (p_Dividend),
        .p_Divisor  (p_Divisor),
        .p_Busy     (p_Busy),
        .p_Done     (p_Done),
        .p_DivZero  (p_DivZero),
        .p_Quotient (p_Quotient),
        .p_Remainder(p_Remainder)
    );

    initial p_Clock = 1'b0;
    always #5 p_Clock = ~p_Clock;

    always @(posedge p_Clock) cyc <= cyc + 1;

    task automatic check_output(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Drives one start pulse from between edges; the next rising edge accepts it.
    task automatic apply_stimulus(input logic [15:0] dividend, input logic [7:0] divisor,
                                  input logic [15:0] quotient, input logic [7:0] remainder);
        expect_t e;
        e.dividend   = dividend;
        e.divisor    = divisor;
        e.quotient   = quotient;
        e.remainder  = remainder;
        e.divzero    = (divisor == 8'd0);
        e.done_cycle = cyc + 1 + ((divisor == 8'd0) ? 0 : 16);
        sb.push_back(e);
        p_Start    = 1'b1;
        p_Dividend = dividend;
        p_Divisor  = divisor;
        @(posedge p_Clock);
        #1;
        p_Start = 1'b0;
    endtask

    task automatic wait_scoreboard_empty(input string name);
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            @(posedge p_Clock);
            #1;
        end
        if (sb.size() != 0) begin
            check_output({name, "_timeout"}, sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic check_cleared(input string name);
        check_output({name, "_busy"}, p_Busy, 0);
        check_output({name, "_done"}, p_Done, 0);
        check_output({name, "_divzero"}, p_DivZero, 0);
        check_output({name, "_quotient"}, p_Quotient, 0);
        check_output({name, "_remainder"}, p_Remainder, 0);
    endtask

    always @(negedge p_Clock) begin
        expect_t e;
        if (!p_Clear) begin
            busy_run = 0;
        end else begin
            if (p_Busy) busy_run++;
            if (p_Done) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check_output("quotient", p_Quotient, e.quotient);
                    check_output("remainder", p_Remainder, e.remainder);
                    check_output("divzero", p_DivZero, e.divzero);
                    check_output("done_latency", cyc, e.done_cycle);
                    check_output("busy_cycles", busy_run, e.divzero ? 0 : 16);
                    if (!e.divzero) begin
                        check_output("invariant", p_Quotient * e.divisor + p_Remainder, e.dividend);
                        check_output("rem_below_div", (p_Remainder < e.divisor), 1);
                    end
                end
                busy_run = 0;
            end
        end
    end

    initial begin
        p_Clear    = 1'b0;
        p_Start    = 1'b0;
        p_Dividend = '0;
        p_Divisor  = '0;
        #1;
        check_cleared("reset");
        repeat (3) @(negedge p_Clock);
        p_Clear = 1'b1;
        @(posedge p_Clock);
        #1;

        apply_stimulus(16'd1000, 8'd7, 16'd142, 8'd6);
        wait_scoreboard_empty("div_1000_7");
        apply_stimulus(16'd65535, 8'd255, 16'd257, 8'd0);
        wait_scoreboard_empty("div_65535_255");
        apply_stimulus(16'd65535, 8'd128, 16'd511, 8'd127);
        wait_scoreboard_empty("div_65535_128");
        apply_stimulus(16'd5, 8'd9, 16'd0, 8'd5);
        wait_scoreboard_empty("div_5_9");
        apply_stimulus(16'd0, 8'd3, 16'd0, 8'd0);
        wait_scoreboard_empty("div_0_3");

        apply_stimulus(16'h04D2, 8'd0, 16'hFFFF, 8'hD2);
        wait_scoreboard_empty("div_by_zero");
        repeat (2) @(posedge p_Clock);
        #1;
        check_output("divzero_held", p_DivZero, 1);
        apply_stimulus(16'd100, 8'd10, 16'd10, 8'd0);
        wait_scoreboard_empty("div_100_10");

        // A start pulse and operand churn during CALC must not disturb the running division.
        apply_stimulus(16'd300, 8'd4, 16'd75, 8'd0);
        repeat (4) @(posedge p_Clock);
        #1;
        p_Start    = 1'b1;
        p_Dividend = 16'd9;
        p_Divisor  = 8'd3;
        @(posedge p_Clock);
        #1;
        p_Start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            p_Dividend = 16'(i * 1111);
            p_Divisor  = 8'(i * 37);
            @(posedge p_Clock);
            #1;
        end
        for (int i = 0; i < 40; i++) begin
            if (p_Done) break;
            @(posedge p_Clock);
            #1;
        end
        check_output("done_seen_for_b2b", p_Done, 1);
        apply_stimulus(16'd50, 8'd6, 16'd8, 8'd2);
        wait_scoreboard_empty("back_to_back");

        // Abandon a division midway through with an asynchronous clear.
        apply_stimulus(16'd1000, 8'd7, 16'd142, 8'd6);
        repeat (8) @(posedge p_Clock);
        #2;
        p_Clear = 1'b0;
        #1;
        check_cleared("async_abort");
        void'(sb.pop_back());
        repeat (2) @(negedge p_Clock);
        p_Clear = 1'b1;
        repeat (24) @(posedge p_Clock);
        #1;
        check_output("idle_after_abort", p_Busy, 0);
        apply_stimulus(16'd1000, 8'd7, 16'd142, 8'd6);
        wait_scoreboard_empty("after_abort");

        repeat (3) @(posedge p_Clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
